// File: rtl/avst_to_avmm_fifo_pkg.sv
// Shared constants for the streaming-capture FIFO: register map, status bit
// positions and control bit positions.
package avst_to_avmm_fifo_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_LEVEL  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_THRESH = 2'd3;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_AFULL    = 2;
  localparam int ST_FULLSEEN = 3;

  localparam int CTRL_FLUSH       = 0;
  localparam int CTRL_CLR_FULLSEEN = 3;

  // Width of the lane counter; a single-lane build still needs one bit.
  function automatic int lane_bits(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/avst_to_avmm_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port. The read
// register only updates when rd_en_i is high, so it doubles as the holding
// register for the FIFO head word.
module avst_to_avmm_fifo_sdp_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rd_data_q;

  // Storage write and synchronous read; no forwarding, the caller never reads
  // an address being written in the same cycle.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/avst_to_avmm_fifo.sv
// Avalon-ST sink to Avalon-MM polled read slave. Stream words are stored in a
// RAM; the oldest word is prefetched into the RAM read register (the head) and
// handed out to the MM side one MM_W lane at a time, LSB lane first.
module avst_to_avmm_fifo
  import avst_to_avmm_fifo_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MM_W          = 16,
  parameter int DEPTH_LOG2    = 10,
  parameter int AFULL_DEFAULT = 1020
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        mm_address,
  input  logic              mm_read,
  input  logic              mm_write,
  input  logic [MM_W-1:0]   mm_writedata,
  output logic [MM_W-1:0]   mm_readdata,
  output logic              mm_readdatavalid,
  output logic              mm_waitrequest
);

  localparam int LANES  = DATA_W / MM_W;
  localparam int LANE_W = lane_bits(LANES);
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]  DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d, thresh_q, thresh_d, ram_cnt;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic                  head_valid_q, head_valid_d;
  logic                  full_seen_q, full_seen_d;
  logic                  rdv_q, rdv_d;
  logic [MM_W-1:0]       rdata_q, rdata_d, rd_value, lane_word;
  logic [DATA_W-1:0]     head_data;

  logic full, afull, push, wr_en, rd_accept, data_accept, pop;
  logic ctrl_wr, flush, fs_clear, fetch;
  logic unused_wdata;

  // count tracks head + RAM contents; the RAM alone holds count minus the head.
  assign full      = (count_q == DEPTH);
  assign afull     = (count_q >= thresh_q);
  assign ram_cnt   = count_q - CNT_W'(head_valid_q);
  assign st_ready  = !reset && !full;
  assign push      = st_valid && st_ready;

  assign mm_waitrequest = mm_read && (mm_address == ADDR_DATA) && !head_valid_q;
  assign rd_accept      = mm_read && !mm_waitrequest;
  assign data_accept    = rd_accept && (mm_address == ADDR_DATA);
  assign pop            = data_accept && (lane_q == LAST_LANE);

  assign ctrl_wr  = mm_write && (mm_address == ADDR_STATUS);
  assign flush    = ctrl_wr && mm_writedata[CTRL_FLUSH];
  assign fs_clear = ctrl_wr && mm_writedata[CTRL_CLR_FULLSEEN];
  assign wr_en    = push && !flush;
  // Refill the head whenever it is empty or being consumed this cycle.
  assign fetch    = (ram_cnt != '0) && (!head_valid_q || pop) && !flush;

  assign lane_word    = head_data[int'(lane_q) * MM_W +: MM_W];
  assign unused_wdata = ^mm_writedata;

  avst_to_avmm_fifo_sdp_ram #(
    .WIDTH  (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (st_data),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_data)
  );

  // FIFO bookkeeping: pointers, occupancy, head-valid and lane position.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    lane_d       = lane_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
      lane_d       = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (fetch) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      if (fetch)    head_valid_d = 1'b1;
      else if (pop) head_valid_d = 1'b0;
      if (data_accept) lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
    end
  end

  // Register map read mux and control/threshold register updates.
  always_comb begin
    rd_value = '0;
    case (mm_address)
      ADDR_DATA:   rd_value = lane_word;
      ADDR_LEVEL:  rd_value[CNT_W-1:0] = count_q;
      ADDR_STATUS: begin
        rd_value[ST_EMPTY]    = !head_valid_q;
        rd_value[ST_FULL]     = full;
        rd_value[ST_AFULL]    = afull;
        rd_value[ST_FULLSEEN] = full_seen_q;
      end
      default:     rd_value[CNT_W-1:0] = thresh_q;
    endcase
    rdv_d   = rd_accept;
    rdata_d = rd_accept ? rd_value : rdata_q;
    // A full cycle sets the sticky flag even if software clears it at once.
    full_seen_d = full ? 1'b1 : (fs_clear ? 1'b0 : full_seen_q);
    thresh_d    = (mm_write && (mm_address == ADDR_THRESH)) ?
                  mm_writedata[CNT_W-1:0] : thresh_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      lane_q       <= '0;
      full_seen_q  <= 1'b0;
      thresh_q     <= CNT_W'(AFULL_DEFAULT);
      rdv_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      lane_q       <= lane_d;
      full_seen_q  <= full_seen_d;
      thresh_q     <= thresh_d;
      rdv_q        <= rdv_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mm_readdata      = rdata_q;
  assign mm_readdatavalid = rdv_q;

endmodule

// File: tb/tb_avst_to_avmm_fifo.sv
// Self-checking bench for avst_to_avmm_fifo with its default parameters
// (32-bit stream, 16-bit MM, 1024 entries).
module tb_avst_to_avmm_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] st_data = '0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [1:0]  mm_address = '0;
  logic        mm_read = 1'b0;
  logic        mm_write = 1'b0;
  logic [15:0] mm_writedata = '0;
  logic [15:0] mm_readdata;
  logic        mm_readdatavalid;
  logic        mm_waitrequest;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  avst_to_avmm_fifo #(
    .DATA_W        (32),
    .MM_W          (16),
    .DEPTH_LOG2    (10),
    .AFULL_DEFAULT (1020)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .st_data          (st_data),
    .st_valid         (st_valid),
    .st_ready         (st_ready),
    .mm_address       (mm_address),
    .mm_read          (mm_read),
    .mm_write         (mm_write),
    .mm_writedata     (mm_writedata),
    .mm_readdata      (mm_readdata),
    .mm_readdatavalid (mm_readdatavalid),
    .mm_waitrequest   (mm_waitrequest)
  );

  // ---------------- reference model ----------------
  // Contents kept as a queue of (word, cycle it was pushed). The front word is
  // readable two cycles after its push.
  typedef struct {
    logic [31:0] data;
    longint      cyc;
  } entry_t;

  entry_t      mq[$];
  int          m_lane = 0;
  bit          m_fs = 1'b0;
  int          m_thresh = 1020;
  bit          m_rdv = 1'b0;
  logic [15:0] m_rdata = '0;
  longint      cyc = 0;

  function automatic bit m_head_ok();
    return (mq.size() > 0) && (cyc >= mq[0].cyc + 2);
  endfunction

  function automatic logic [15:0] m_read_value(input logic [1:0] a);
    logic [15:0] r;
    r = '0;
    case (a)
      2'd0: if (mq.size() > 0) r = (m_lane == 1) ? mq[0].data[31:16] : mq[0].data[15:0];
      2'd1: r = 16'(mq.size());
      2'd2: r = {12'd0, m_fs, (mq.size() >= m_thresh), (mq.size() == 1024), !m_head_ok()};
      default: r = 16'(m_thresh);
    endcase
    return r;
  endfunction

  always @(posedge clock) begin : ref_model
    bit hok, push, acc, pop, ctrl, flush;
    logic [15:0] val;
    if (reset) begin
      mq.delete();
      m_lane = 0; m_fs = 1'b0; m_thresh = 1020; m_rdv = 1'b0; m_rdata = '0;
    end else begin
      hok   = m_head_ok();
      push  = st_valid && (mq.size() != 1024);
      acc   = mm_read && ((mm_address != 2'd0) || hok);
      ctrl  = mm_write && (mm_address == 2'd2);
      flush = ctrl && mm_writedata[0];
      val   = m_read_value(mm_address);
      m_rdv = acc;
      if (acc) m_rdata = val;
      pop = acc && (mm_address == 2'd0) && (m_lane == 1);
      if (acc && mm_address == 2'd0) m_lane = (m_lane + 1) % 2;
      if (mq.size() == 1024) m_fs = 1'b1;
      else if (ctrl && mm_writedata[3]) m_fs = 1'b0;
      if (mm_write && mm_address == 2'd3) m_thresh = int'(mm_writedata & 16'h07FF);
      if (flush) begin
        mq.delete();
        m_lane = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{st_data, cyc});
      end
    end
    cyc++;
  end

  // ---------------- bus drivers (no checking) ----------------
  task automatic mm_rd(input logic [1:0] a, output logic [15:0] d, output logic v,
                       output int stalls);
    mm_address = a;
    mm_read    = 1'b1;
    stalls     = 0;
    #1;
    while (mm_waitrequest === 1'b1 && stalls < 200) begin
      @(negedge clock); #1;
      stalls++;
    end
    if (mm_waitrequest === 1'b1) begin
      mm_read = 1'b0;
      d = 'x;
      v = 1'b0;
    end else begin
      @(negedge clock);
      d = mm_readdata;
      v = mm_readdatavalid;
      mm_read = 1'b0;
    end
  endtask

  task automatic mm_wr(input logic [1:0] a, input logic [15:0] wd);
    mm_address   = a;
    mm_writedata = wd;
    mm_write     = 1'b1;
    @(negedge clock);
    mm_write = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, output bit ok);
    int n;
    n = 0;
    st_data  = w;
    st_valid = 1'b1;
    #1;
    while (st_ready !== 1'b1 && n < 2000) begin
      @(negedge clock); #1;
      n++;
    end
    ok = (st_ready === 1'b1);
    if (ok) @(negedge clock);
    st_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] d; logic v; int s;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_st_ready: got %b want 0", st_ready); end
    checks++;
    if (mm_readdatavalid !== 1'b0 || mm_readdata !== 16'h0000) begin
      errors++; $display("FAIL reset_readdata: got valid=%b data=%h want 0/0000", mm_readdatavalid, mm_readdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (st_ready !== 1'b1 || mm_waitrequest !== 1'b0) begin
      errors++; $display("FAIL reset_release: got ready=%b wait=%b want 1/0", st_ready, mm_waitrequest);
    end
    @(negedge clock);
    mm_rd(2'd1, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL reset_level: got %h valid=%b want 0000", d, v); end
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0001) begin errors++; $display("FAIL reset_status: got %h valid=%b want 0001", d, v); end
    mm_rd(2'd3, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd1020) begin errors++; $display("FAIL reset_thresh: got %0d valid=%b want 1020", d, v); end
  endtask

  task automatic test_basic();
    logic [15:0] d; logic v; int s; bit ok;
    push_word(32'hAABBCCDD, ok);
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'hCCDD) begin errors++; $display("FAIL basic_lane0: got %h valid=%b want ccdd", d, v); end
    mm_rd(2'd1, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd1) begin errors++; $display("FAIL basic_level1: got %h want 0001", d); end
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'hAABB) begin errors++; $display("FAIL basic_lane1: got %h valid=%b want aabb", d, v); end
    @(negedge clock);
    checks++;
    if (mm_readdatavalid !== 1'b0 || mm_readdata !== 16'hAABB) begin
      errors++; $display("FAIL basic_hold: got valid=%b data=%h want 0/aabb", mm_readdatavalid, mm_readdata);
    end
    mm_rd(2'd1, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL basic_level0: got %h want 0000", d); end
  endtask

  task automatic test_wait_empty();
    logic [15:0] d; logic v; int s;
    mm_address = 2'd0;
    mm_read    = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mm_waitrequest !== 1'b1) begin errors++; $display("FAIL wait_empty_%0d: got %b want 1", i, mm_waitrequest); end
      @(negedge clock); #1;
    end
    st_data  = 32'h12345678;
    st_valid = 1'b1;
    #1;
    checks++;
    if (mm_waitrequest !== 1'b1) begin errors++; $display("FAIL wait_t0: got %b want 1", mm_waitrequest); end
    @(negedge clock);
    st_valid = 1'b0;
    #1;
    checks++;
    if (mm_waitrequest !== 1'b1) begin errors++; $display("FAIL wait_t1: got %b want 1", mm_waitrequest); end
    @(negedge clock); #1;
    checks++;
    if (mm_waitrequest !== 1'b0) begin errors++; $display("FAIL wait_t2: got %b want 0", mm_waitrequest); end
    @(negedge clock);
    checks++;
    if (mm_readdatavalid !== 1'b1 || mm_readdata !== 16'h5678) begin
      errors++; $display("FAIL wait_data: got valid=%b data=%h want 1/5678", mm_readdatavalid, mm_readdata);
    end
    mm_read = 1'b0;
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h1234) begin errors++; $display("FAIL wait_lane1: got %h want 1234", d); end
  endtask

  task automatic test_fill();
    logic [15:0] d; logic v; int s; int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      st_data  = 32'(i);
      st_valid = 1'b1;
      #1;
      if (st_ready !== 1'b1) bad++;
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_ready: st_ready low on %0d of 1024 pushes, want 0", bad); end
    st_data = 32'd1024;
    #1;
    checks++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b want 0", st_ready); end
    st_valid = 1'b0;
    mm_rd(2'd1, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd1024) begin errors++; $display("FAIL fill_level: got %0d want 1024", d); end
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h000E) begin errors++; $display("FAIL fill_status: got %h want 000e", d); end
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL fill_w0_lo: got %h want 0000", d); end
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL fill_w0_hi: got %h want 0000", d); end
    #1;
    checks++;
    if (st_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after_pop: got %b want 1", st_ready); end
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h000C) begin errors++; $display("FAIL fill_sticky: got %h want 000c", d); end
    mm_wr(2'd2, 16'h0008);
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0004) begin errors++; $display("FAIL fill_sticky_clear: got %h want 0004", d); end
    bad = 0;
    for (int i = 1; i < 1024; i++) begin
      mm_rd(2'd0, d, v, s);
      if (v !== 1'b1 || d !== 16'(i)) begin
        if (bad == 0) $display("FAIL fill_drain_lo: word %0d got %h want %h", i, d, 16'(i));
        bad++;
      end
      mm_rd(2'd0, d, v, s);
      if (v !== 1'b1 || d !== 16'h0000) begin
        if (bad == 0) $display("FAIL fill_drain_hi: word %0d got %h want 0000", i, d);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0001) begin errors++; $display("FAIL fill_drained_status: got %h want 0001", d); end
  endtask

  task automatic test_thresh();
    logic [15:0] d; logic v; int s; bit ok;
    logic [31:0] w [4];
    mm_wr(2'd3, 16'hF804);
    mm_rd(2'd3, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0004) begin errors++; $display("FAIL thresh_readback: got %h want 0004", d); end
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    for (int i = 0; i < 3; i++) push_word(w[i], ok);
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL thresh_below: got %h want 0000", d); end
    push_word(w[3], ok);
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0004) begin errors++; $display("FAIL thresh_at: got %h want 0004", d); end
    for (int i = 0; i < 4; i++) begin
      mm_rd(2'd0, d, v, s);
      checks++;
      if (v !== 1'b1 || d !== w[i][15:0]) begin errors++; $display("FAIL thresh_data_lo%0d: got %h want %h", i, d, w[i][15:0]); end
      mm_rd(2'd0, d, v, s);
      checks++;
      if (v !== 1'b1 || d !== w[i][31:16]) begin errors++; $display("FAIL thresh_data_hi%0d: got %h want %h", i, d, w[i][31:16]); end
    end
  endtask

  task automatic test_flush();
    logic [15:0] d; logic v; int s; bit ok;
    logic [31:0] w0, nw;
    w0 = $urandom;
    push_word(w0, ok);
    for (int i = 0; i < 4; i++) push_word($urandom, ok);
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== w0[15:0]) begin errors++; $display("FAIL flush_pre_lane: got %h want %h", d, w0[15:0]); end
    mm_address   = 2'd2;
    mm_writedata = 16'h0001;
    mm_write     = 1'b1;
    st_data      = $urandom;
    st_valid     = 1'b1;
    #1;
    checks++;
    if (st_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", st_ready); end
    @(negedge clock);
    mm_write = 1'b0;
    st_valid = 1'b0;
    mm_rd(2'd1, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL flush_level: got %h want 0000", d); end
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0001) begin errors++; $display("FAIL flush_status: got %h want 0001", d); end
    nw = $urandom;
    push_word(nw, ok);
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== nw[15:0]) begin errors++; $display("FAIL flush_new_lo: got %h want %h", d, nw[15:0]); end
    mm_rd(2'd0, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== nw[31:16]) begin errors++; $display("FAIL flush_new_hi: got %h want %h", d, nw[31:16]); end
  endtask

  task automatic test_random();
    int r;
    bit exp_wait;
    for (int n = 0; n < 800; n++) begin
      checks++;
      if (mm_readdatavalid !== m_rdv || mm_readdata !== m_rdata) begin
        errors++;
        $display("FAIL rand_read c%0d: got valid=%b data=%h want %b/%h", n, mm_readdatavalid, mm_readdata, m_rdv, m_rdata);
      end
      st_valid = ($urandom_range(0, 9) < 6);
      st_data  = $urandom;
      r = $urandom_range(0, 19);
      mm_read  = (r < 9);
      mm_write = (r >= 18);
      mm_address = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      if (mm_write && mm_address == 2'd3) mm_writedata = 16'($urandom_range(0, 12)) | 16'($urandom & 32'hF800);
      else if (mm_write) mm_writedata = 16'($urandom & 32'hFFFE) | 16'($urandom_range(0, 5) == 0);
      #1;
      exp_wait = mm_read && (mm_address == 2'd0) && !m_head_ok();
      checks++;
      if (st_ready !== (mq.size() != 1024) || mm_waitrequest !== exp_wait) begin
        errors++;
        $display("FAIL rand_comb c%0d: got ready=%b wait=%b want %b/%b", n, st_ready, mm_waitrequest, (mq.size() != 1024), exp_wait);
      end
      @(negedge clock);
    end
    st_valid = 1'b0; mm_read = 1'b0; mm_write = 1'b0;
    checks++;
    if (mm_readdatavalid !== m_rdv || mm_readdata !== m_rdata) begin
      errors++; $display("FAIL rand_last: got %b/%h want %b/%h", mm_readdatavalid, mm_readdata, m_rdv, m_rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic v; int s; bit ok;
    mm_wr(2'd3, 16'd5);
    mm_wr(2'd2, 16'h0001);
    for (int i = 0; i < 10; i++) push_word($urandom, ok);
    mm_rd(2'd1, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd10) begin errors++; $display("FAIL mid_level10: got %0d want 10", d); end
    mm_address = 2'd0;
    mm_read    = 1'b1;
    reset      = 1'b1;
    #1;
    checks++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL mid_ready0: got %b want 0", st_ready); end
    @(negedge clock);
    checks++;
    if (mm_readdatavalid !== 1'b0 || mm_readdata !== 16'h0000) begin
      errors++; $display("FAIL mid_rdv: got valid=%b data=%h want 0/0000", mm_readdatavalid, mm_readdata);
    end
    mm_read = 1'b0;
    #1;
    checks++;
    if (st_ready !== 1'b0) begin errors++; $display("FAIL mid_ready1: got %b want 0", st_ready); end
    @(negedge clock);
    reset = 1'b0;
    mm_rd(2'd1, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", d); end
    mm_rd(2'd3, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'd1020) begin errors++; $display("FAIL mid_thresh: got %0d want 1020", d); end
    mm_rd(2'd2, d, v, s);
    checks++;
    if (v !== 1'b1 || d !== 16'h0001) begin errors++; $display("FAIL mid_status: got %h want 0001", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_empty();
    test_fill();
    test_thresh();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
